attr_recon_sequencer: RTL and testbench
=======================================

# attr_recon_sequencer

Frame-level sequencer for attribute reconstruction in the LiDAR attribute decompressor. It accepts a stream of signed residuals for one frame of `point_count` points and forms a prediction for each point from previously reconstructed attributes. It adds the residual with saturating clamp, the same arithmetic as the attribute combiner, and emits reconstructed attributes on a valid/ready stream with last and done markers. It sits between the residual entropy decoder and the point assembler.

## Interface
- `ATTR_WIDTH`, 8, width of an unsigned attribute and of a signed residual.
- `CNT_WIDTH`, 16, width of the point counter and the saturation counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  frame start; sampled only in IDLE.
- `point_count`  in  CNT_WIDTH  points in the frame; latched on start.
- `pred_mode`  in  1  predictor: 0 = previous value, 1 = mean of the last two; latched on start.
- `init_attr`  in  ATTR_WIDTH  seed for the history registers; latched on start.
- `res_valid`  in  1  residual valid.
- `res_ready`  out  1  residual accepted when high with `res_valid`.
- `residual`  in  ATTR_WIDTH  signed two's-complement residual.
- `attr_valid`  out  1  reconstructed attribute valid.
- `attr_ready`  in  1  downstream accepts.
- `attr_data`  out  ATTR_WIDTH  reconstructed attribute.
- `attr_sat`  out  1  this attribute was clamped.
- `attr_last`  out  1  this is the final attribute of the frame.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at frame end.
- `sat_count`  out  CNT_WIDTH  number of clamped attributes in the current/last frame.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE with `start` high:
  - Latch `point_count` into cnt_target and `pred_mode` into the mode register.
  - Set hist0 = hist1 = `init_attr`, clear the accept counter, clear `sat_count`.
  - Go to RUN, or to DONE when `point_count` == 0.
- `start` outside IDLE is ignored.
- RUN: a residual is accepted on `res_valid && res_ready`.
- Prediction:
  - mode 0: pred = hist0.
  - mode 1: pred = (hist0 + hist1) >> 1, with the sum in ATTR_WIDTH+1 bits and the shift flooring.
- Combine: temp = {0,pred} + sign-extended residual, computed in ATTR_WIDTH+2 signed bits.
  - temp < 0: result 0, sat = 1.
  - temp > 2^ATTR_WIDTH − 1: result 2^ATTR_WIDTH − 1, sat = 1.
  - Otherwise: result = temp[ATTR_WIDTH-1:0], sat = 0.
- On accept:
  - Register the result into `attr_data` and the flag into `attr_sat`; set `attr_valid`.
  - Shift history: hist1 ← hist0, hist0 ← result.
  - Increment the accept counter.
  - If sat, increment `sat_count`; it saturates at all-ones and does not wrap.
- On the accept where the counter equals cnt_target − 1: set `attr_last` with that output and go to DRAIN.
- DRAIN: hold until the output handshake `attr_valid && attr_ready`, then go to DONE.
- DONE: `done` = 1 for exactly this cycle, then go to IDLE. `sat_count` holds until the next accepted start.
- `attr_valid` clears on handshake unless a new accept occurs in the same cycle.
- `attr_data`, `attr_sat` and `attr_last` hold stable while `attr_valid && !attr_ready`.
- Reset, including mid-frame: state IDLE, all outputs 0 (`res_ready`, `attr_valid`, `attr_data`, `attr_sat`, `attr_last`, `busy`, `done`, `sat_count`), history 0, counters 0. Any in-flight frame is discarded.

## Timing
- `res_ready` = (state == RUN) && (!`attr_valid` || `attr_ready`). This is combinational from `attr_ready`; there are no other combinational in-to-out paths.
- Latency: an attribute is valid the cycle after its residual is accepted.
- Throughput: one point per cycle with `attr_ready` held high. Back-to-back accepts use the history updated at the previous edge, so no bubbles occur.
- An accept and the output handshake may occur in the same cycle; the output register is overwritten with the new value.
- Zero-count frame: `start` in cycle N gives `busy` = 1 and `done` = 1 in cycle N+1, with no outputs.
- Normal frame: `done` is high in the cycle after the handshake of the `attr_last` beat. `start` is accepted again the cycle after `done`.
- `busy` is high from the cycle after `start` through the `done` cycle inclusive.

## Test plan
- Mode 0, seed 100, count 3, residuals +10, −20, +5, `attr_ready` = 1 → outputs 110, 90, 95 on consecutive cycles; `attr_last` on 95; `done` one cycle later; `sat_count` = 0.
- Saturation, mode 0:
  - Seed 250, residuals +10, −128 → 255 (`attr_sat` = 1), then 127.
  - New frame, seed 5, residual −10 → 0 (`attr_sat` = 1).
  - Each frame's `sat_count` = 1.
- Mode 1, seed 100, residuals +20, −10, 0 → 120 (pred 100), 100 (pred 110), 110 (pred 110).
- Backpressure: mode 0, seed 0, count 4, residuals +1 each; `attr_ready` low for 3 cycles after the first output → `res_ready` low, `attr_data` held at 1. Outputs then 1, 2, 3, 4 with no loss or duplication.
- `point_count` = 0 → no `attr_valid`; `done` pulse exactly one cycle after `start`; `start` during RUN has no effect.
- Reset mid-frame after 2 of 5 outputs → next cycle all outputs 0, state IDLE. A new start with seed 50 and residual +1 yields 51.

Source files
------------

// File: rtl/attr_recon_sequencer.sv
// -----------------------------------------------------------------------------
// attr_recon_sequencer
//
// Frame-level sequencer for attribute reconstruction in the LiDAR attribute
// decompressor. For each frame of point_count points it takes one signed
// residual per point and predicts the point from previously reconstructed
// attributes. It adds the residual with a saturating clamp and emits the
// reconstructed attribute on a valid/ready stream. The stream carries last and
// done markers.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   start        frame start, sampled only while idle
//   point_count  points in the frame (latched on start)
//   pred_mode    0 = previous value, 1 = floor mean of last two (latched)
//   init_attr    seed for both history registers (latched on start)
//   res_valid    residual valid
//   res_ready    residual accepted when high together with res_valid
//   residual     signed two's-complement residual
//   attr_valid   reconstructed attribute valid
//   attr_ready   downstream accepts the attribute
//   attr_data    reconstructed attribute
//   attr_sat     this attribute was clamped
//   attr_last    final attribute of the frame
//   busy         sequencer is not idle
//   done         one-cycle pulse at frame end
//   sat_count    clamped attributes in the current/last frame (saturating)
// -----------------------------------------------------------------------------
module attr_recon_sequencer #(
  parameter int ATTR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  point_count,
  input  logic                  pred_mode,
  input  logic [ATTR_WIDTH-1:0] init_attr,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [ATTR_WIDTH-1:0] residual,
  output logic                  attr_valid,
  input  logic                  attr_ready,
  output logic [ATTR_WIDTH-1:0] attr_data,
  output logic                  attr_sat,
  output logic                  attr_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [CNT_WIDTH-1:0]  cnt_target;
  logic [CNT_WIDTH-1:0]  acc_cnt;
  logic                  mode;
  logic [ATTR_WIDTH-1:0] hist0;
  logic [ATTR_WIDTH-1:0] hist1;

  logic                  accept;
  logic                  handshake;
  logic                  last_accept;
  logic [ATTR_WIDTH:0]   pred_sum;
  logic [ATTR_WIDTH-1:0] pred;
  logic signed [ATTR_WIDTH+1:0] temp;
  logic [ATTR_WIDTH-1:0] comb_result;
  logic                  comb_sat;

  // ---------------------------------------------------------------------------
  // Handshakes and status
  // ---------------------------------------------------------------------------
  // A new residual is taken only when the output register is free or is
  // emptied in the same cycle. This gives one point per clock with no bubble.
  assign res_ready = (state == RUN) && (!attr_valid || attr_ready);
  assign accept    = res_valid && res_ready;
  assign handshake = attr_valid && attr_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // The counter counts accepts so far, so the final point is the one
  // accepted while it is one below the target.
  assign last_accept = ((acc_cnt + CNT_ONE) == cnt_target);

  // ---------------------------------------------------------------------------
  // Prediction and saturating combine
  // ---------------------------------------------------------------------------
  // The extra bit keeps the carry of the mean, so the shift floors exactly.
  assign pred_sum = {1'b0, hist0} + {1'b0, hist1};
  assign pred     = mode ? ATTR_WIDTH'(pred_sum >> 1) : hist0;

  // Two guard bits: the top bit is the sign, the next bit flags overflow
  // above the unsigned attribute range.
  assign temp = $signed({2'b00, pred})
              + $signed({{2{residual[ATTR_WIDTH-1]}}, residual});

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    comb_result = temp[ATTR_WIDTH-1:0];
    comb_sat    = 1'b0;
    if (temp[ATTR_WIDTH+1]) begin
      comb_result = '0;
      comb_sat    = 1'b1;
    end else if (temp[ATTR_WIDTH]) begin
      comb_result = '1;
      comb_sat    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments. Every register
    // then samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = (point_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && last_accept) state_next = DRAIN;
      end
      DRAIN: begin
        if (handshake) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: frame setup, history, counters and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the history and the output registers are cleared by reset. A frame
    // cut short by reset then leaves no stale prediction seed or beat behind.
    if (rst) begin
      cnt_target <= '0;
      acc_cnt    <= '0;
      mode       <= 1'b0;
      hist0      <= '0;
      hist1      <= '0;
      sat_count  <= '0;
      attr_valid <= 1'b0;
      attr_data  <= '0;
      attr_sat   <= 1'b0;
      attr_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt_target <= point_count;
        mode       <= pred_mode;
        hist0      <= init_attr;
        hist1      <= init_attr;
        acc_cnt    <= '0;
        sat_count  <= '0;
      end

      // An accept and an output handshake can occur in the same cycle. In that
      // case the new beat overwrites the one just consumed.
      if (accept) begin
        attr_valid <= 1'b1;
        attr_data  <= comb_result;
        attr_sat   <= comb_sat;
        attr_last  <= last_accept;
        hist1      <= hist0;
        hist0      <= comb_result;
        acc_cnt    <= acc_cnt + CNT_ONE;
        if (comb_sat && (sat_count != '1)) sat_count <= sat_count + CNT_ONE;
      end else if (handshake) begin
        attr_valid <= 1'b0;
        attr_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attr_recon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_attr_recon_sequencer
//
// Directed bench for attr_recon_sequencer. Inputs change 1 ns after a rising
// edge. Outputs are checked 1 ns after an edge, or 1 ns after an input change
// for the combinational res_ready. Expected values are computed by hand.
// -----------------------------------------------------------------------------
module tb_attr_recon_sequencer;

  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] point_count;
  logic          pred_mode;
  logic [AW-1:0] init_attr;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] residual;
  logic          attr_valid;
  logic          attr_ready;
  logic [AW-1:0] attr_data;
  logic          attr_sat;
  logic          attr_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  attr_recon_sequencer #(.ATTR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .point_count (point_count),
    .pred_mode   (pred_mode),
    .init_attr   (init_attr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .residual    (residual),
    .attr_valid  (attr_valid),
    .attr_ready  (attr_ready),
    .attr_data   (attr_data),
    .attr_sat    (attr_sat),
    .attr_last   (attr_last),
    .busy        (busy),
    .done        (done),
    .sat_count   (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and check that the sequencer went busy.
  task automatic start_frame(input logic [CW-1:0] cnt, input logic mode, input logic [AW-1:0] seed);
    start       = 1'b1;
    point_count = cnt;
    pred_mode   = mode;
    init_attr   = seed;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Present one residual for one edge and check the registered beat.
  task automatic send(input string tag, input logic [AW-1:0] res,
                      input logic [AW-1:0] exp_data, input logic exp_sat, input logic exp_last);
    residual  = res;
    res_valid = 1'b1;
    #1;
    check({tag, "_res_ready"}, res_ready, 1);
    tick();
    res_valid = 1'b0;
    check({tag, "_valid"}, attr_valid, 1);
    check({tag, "_data"}, attr_data, exp_data);
    check({tag, "_sat"}, attr_sat, exp_sat);
    check({tag, "_last"}, attr_last, exp_last);
  endtask

  // The last beat is held in DRAIN with attr_ready high. The next edge enters
  // DONE, and the edge after that returns to IDLE.
  task automatic finish_frame(input string tag, input logic [CW-1:0] exp_sat_cnt);
    res_valid = 1'b0;
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_in_done"}, busy, 1);
    check({tag, "_valid_in_done"}, attr_valid, 0);
    tick();
    check({tag, "_done_cleared"}, done, 0);
    check({tag, "_busy_cleared"}, busy, 0);
    check({tag, "_sat_count"}, sat_count, exp_sat_cnt);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    point_count = '0;
    pred_mode   = 1'b0;
    init_attr   = '0;
    res_valid   = 1'b0;
    residual    = '0;
    attr_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_res_ready", res_ready, 0);
    check("rst_attr_valid", attr_valid, 0);
    check("rst_attr_data", attr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat_count", sat_count, 0);
    rst = 1'b0;
    tick();

    // Mode 0, seed 100: 110, 90, 95
    start_frame(16'd3, 1'b0, 8'd100);
    send("m0_a", 8'd10,   8'd110, 1'b0, 1'b0);
    send("m0_b", 8'hEC,   8'd90,  1'b0, 1'b0);
    send("m0_c", 8'd5,    8'd95,  1'b0, 1'b1);
    finish_frame("m0", 16'd0);

    // Saturation high then in range: 250+10 -> 255 sat, 255-128 -> 127
    start_frame(16'd2, 1'b0, 8'd250);
    send("sat_hi", 8'd10, 8'd255, 1'b1, 1'b0);
    send("sat_mid", 8'h80, 8'd127, 1'b0, 1'b1);
    finish_frame("sat1", 16'd1);

    // Saturation low: 5-10 -> 0 sat
    start_frame(16'd1, 1'b0, 8'd5);
    send("sat_lo", 8'hF6, 8'd0, 1'b1, 1'b1);
    finish_frame("sat2", 16'd1);

    // Mode 1, seed 100: 120, 100, 110
    start_frame(16'd3, 1'b1, 8'd100);
    send("m1_a", 8'd20, 8'd120, 1'b0, 1'b0);
    send("m1_b", 8'hF6, 8'd100, 1'b0, 1'b0);
    send("m1_c", 8'd0,  8'd110, 1'b0, 1'b1);
    finish_frame("m1", 16'd0);

    // Backpressure: seed 0, four +1 residuals, ready low for 3 cycles
    start_frame(16'd4, 1'b0, 8'd0);
    send("bp_1", 8'd1, 8'd1, 1'b0, 1'b0);
    res_valid  = 1'b1;
    attr_ready = 1'b0;
    #1;
    check("bp_res_ready_low", res_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", attr_valid, 1);
      check("bp_hold_data", attr_data, 1);
      check("bp_hold_res_ready", res_ready, 0);
    end
    attr_ready = 1'b1;
    #1;
    check("bp_res_ready_back", res_ready, 1);
    tick();
    check("bp_2_data", attr_data, 2);
    check("bp_2_last", attr_last, 0);
    tick();
    check("bp_3_data", attr_data, 3);
    tick();
    check("bp_4_data", attr_data, 4);
    check("bp_4_last", attr_last, 1);
    res_valid = 1'b0;
    finish_frame("bp", 16'd0);

    // Zero-count frame: done the cycle after start, no output
    start_frame(16'd0, 1'b0, 8'd7);
    check("zero_done", done, 1);
    check("zero_valid", attr_valid, 0);
    tick();
    check("zero_done_cleared", done, 0);
    check("zero_busy_cleared", busy, 0);
    check("zero_valid_after", attr_valid, 0);

    // Start during RUN is ignored: the seed stays 10 and the count stays 2
    start_frame(16'd2, 1'b0, 8'd10);
    start       = 1'b1;
    point_count = 16'd0;
    init_attr   = 8'd200;
    send("ign_a", 8'd1, 8'd11, 1'b0, 1'b0);
    start = 1'b1;
    send("ign_b", 8'd1, 8'd12, 1'b0, 1'b1);
    start       = 1'b0;
    point_count = '0;
    finish_frame("ign", 16'd0);

    // Reset mid-frame after two of five outputs (one clamped)
    start_frame(16'd5, 1'b0, 8'd0);
    send("mid_a", 8'hFF, 8'd0, 1'b1, 1'b0);
    send("mid_b", 8'd2,  8'd2, 1'b0, 1'b0);
    check("mid_sat_count", sat_count, 1);
    res_valid = 1'b1;
    residual  = 8'd1;
    rst       = 1'b1;
    tick();
    check("mid_rst_valid", attr_valid, 0);
    check("mid_rst_data", attr_data, 0);
    check("mid_rst_sat", attr_sat, 0);
    check("mid_rst_last", attr_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sat_count", sat_count, 0);
    check("mid_rst_res_ready", res_ready, 0);
    rst       = 1'b0;
    res_valid = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    // Fresh frame after reset: seed 50, +1 -> 51
    start_frame(16'd1, 1'b0, 8'd50);
    send("post_rst", 8'd1, 8'd51, 1'b0, 1'b1);
    finish_frame("post", 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
